// File: rtl/paint_pkg.sv
// Shared types for the painterly renderer front end: pixel packing,
// per-pixel difference width and the region-loader state encoding.
package paint_pkg;

    localparam int unsigned GRID_SZ  = 8;
    localparam int unsigned GRID_PIX = GRID_SZ * GRID_SZ;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [9:0] diff_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

endpackage

// File: rtl/color_abs_diff.sv
// Combinational colour distance: |dR| + |dG| + |dB| between two RGB pixels.
module color_abs_diff
    import paint_pkg::*;
(
    input  rgb_t  a_rgb,
    input  rgb_t  b_rgb,
    output diff_t diff
);

    function automatic logic [7:0] abs_d(input logic [7:0] x, input logic [7:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    always_comb begin
        diff = diff_t'(abs_d(a_rgb.r, b_rgb.r))
             + diff_t'(abs_d(a_rgb.g, b_rgb.g))
             + diff_t'(abs_d(a_rgb.b, b_rgb.b));
    end

endmodule

// File: rtl/grid_diff_loader.sv
// Buffers one 8x8 cell of per-pixel colour differences, accumulates the
// cell's area error and hands the region downstream over valid/ready.
module grid_diff_loader
    import paint_pkg::*;
#(
    parameter int unsigned DIFF_W      = 24,
    parameter int unsigned GRIDS_X     = 40,
    parameter int unsigned GRIDS_Y     = 30,
    parameter logic [15:0] AREA_THRESH = 16'd3200
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_pix_valid,
    output logic                         o_pix_ready,
    input  logic [23:0]                  i_ref_rgb,
    input  logic [23:0]                  i_cvs_rgb,
    output logic [GRID_PIX*DIFF_W-1:0]   o_region,
    output logic [15:0]                  o_area_err,
    output logic                         o_paint,
    output logic [$clog2(GRIDS_X)-1:0]   o_grid_x,
    output logic [$clog2(GRIDS_Y)-1:0]   o_grid_y,
    output logic                         o_reg_valid,
    input  logic                         i_reg_ready,
    output logic                         o_frame_done
);

    localparam int unsigned GX_W = $clog2(GRIDS_X);
    localparam int unsigned GY_W = $clog2(GRIDS_Y);

    state_t              state;
    state_t              state_nxt;
    logic [5:0]          cnt;
    logic [15:0]         acc;
    logic [DIFF_W-1:0]   region [GRID_PIX];
    logic [GX_W-1:0]     grid_x;
    logic [GY_W-1:0]     grid_y;
    diff_t               pix_diff;
    logic                pix_acc;
    logic                last_x;
    logic                last_cell;

    color_abs_diff u_diff (
        .a_rgb (rgb_t'(i_ref_rgb)),
        .b_rgb (rgb_t'(i_cvs_rgb)),
        .diff  (pix_diff)
    );

    assign pix_acc   = i_pix_valid & o_pix_ready;
    assign last_x    = (grid_x == GX_W'(GRIDS_X - 1));
    assign last_cell = last_x && (grid_y == GY_W'(GRIDS_Y - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = FILL;
            FILL: if (pix_acc && cnt == 6'(GRID_PIX - 1)) state_nxt = HOLD;
            HOLD: if (i_reg_ready) state_nxt = last_cell ? IDLE : FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready = (state == FILL);
        o_reg_valid = (state == HOLD);
    end

    // Region index r*8+c equals the raster count, so cnt addresses it directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            acc          <= '0;
            grid_x       <= '0;
            grid_y       <= '0;
            o_frame_done <= 1'b0;
            for (int unsigned i = 0; i < GRID_PIX; i++) begin
                region[i] <= '0;
            end
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        grid_x <= '0;
                        grid_y <= '0;
                    end
                end
                FILL: begin
                    if (pix_acc) begin
                        region[cnt] <= DIFF_W'(pix_diff);
                        acc         <= acc + 16'(pix_diff);
                        cnt         <= cnt + 6'd1;
                    end
                end
                HOLD: begin
                    if (i_reg_ready) begin
                        if (last_cell) begin
                            o_frame_done <= 1'b1;
                        end else begin
                            acc <= '0;
                            if (last_x) begin
                                grid_x <= '0;
                                grid_y <= grid_y + GY_W'(1);
                            end else begin
                                grid_x <= grid_x + GX_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_region = '0;
        for (int unsigned i = 0; i < GRID_PIX; i++) begin
            o_region[i*DIFF_W +: DIFF_W] = region[i];
        end
    end

    assign o_area_err = acc;
    assign o_paint    = (acc > AREA_THRESH);
    assign o_grid_x   = grid_x;
    assign o_grid_y   = grid_y;

endmodule

// File: tb/tb_grid_diff_loader.sv
// Directed bench for grid_diff_loader on a 2x2 grid: difference arithmetic,
// handshake stall, frame sequencing, threshold boundary and mid-fill reset.
module tb_grid_diff_loader;

    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            pix_valid;
    logic            pix_ready;
    logic [23:0]     ref_rgb;
    logic [23:0]     cvs_rgb;
    logic [64*DW-1:0] region;
    logic [15:0]     area_err;
    logic            paint;
    logic            grid_x;
    logic            grid_y;
    logic            reg_valid;
    logic            reg_ready;
    logic            frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0]      ref_a [64];
    logic [23:0]      cvs_a [64];
    logic [64*DW-1:0] exp_vec;

    grid_diff_loader #(
        .DIFF_W      (DW),
        .GRIDS_X     (2),
        .GRIDS_Y     (2),
        .AREA_THRESH (16'd3200)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_pix_valid  (pix_valid),
        .o_pix_ready  (pix_ready),
        .i_ref_rgb    (ref_rgb),
        .i_cvs_rgb    (cvs_rgb),
        .o_region     (region),
        .o_area_err   (area_err),
        .o_paint      (paint),
        .o_grid_x     (grid_x),
        .o_grid_y     (grid_y),
        .o_reg_valid  (reg_valid),
        .i_reg_ready  (reg_ready),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int first_diff(input logic [64*DW-1:0] got, input logic [64*DW-1:0] exp);
        for (int i = 0; i < 64; i++) begin
            if (got[i*DW +: DW] !== exp[i*DW +: DW]) return i;
        end
        return -1;
    endfunction

    task automatic drive_pixels(input int first, input int n, output int stalls);
        int i = first;
        stalls = 0;
        while (i < first + n && stalls < 100) begin
            @(negedge clk);
            pix_valid = 1'b1;
            ref_rgb   = ref_a[i];
            cvs_rgb   = cvs_a[i];
            if (pix_ready) i++;
            else stalls++;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        pix_valid = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic accept_region();
        @(negedge clk);
        reg_ready = 1'b1;
        @(negedge clk);
        reg_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; reg_ready = 1'b0;
        ref_rgb = '0; cvs_rgb = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready got %b exp 0", pix_ready); end
        n_checks++; if (reg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_reg_valid got %b exp 0", reg_valid); end
        n_checks++; if (area_err !== 16'd0) begin n_fail++; $display("FAIL reset_area got %0d exp 0", area_err); end
        n_checks++; if (paint !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got paint=%b done=%b exp 0 0", paint, frame_done); end
        n_checks++; if (grid_x !== 1'b0 || grid_y !== 1'b0) begin n_fail++; $display("FAIL reset_grid got (%0d,%0d) exp (0,0)", grid_x, grid_y); end
        n_checks++; if (region !== '0) begin n_fail++; $display("FAIL reset_region elem %0d nonzero exp 0", first_diff(region, '0)); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL idle_no_ready got %b exp 0", pix_ready); end
    endtask

    task automatic test_uniform(input string tag);
        int st;
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = 24'h000000; cvs_a[i] = 24'h010203;
            exp_vec[i*DW +: DW] = DW'(6);
        end
        start_frame();
        n_checks++; if (grid_x !== 1'b0 || grid_y !== 1'b0) begin n_fail++; $display("FAIL %s_start_grid got (%0d,%0d) exp (0,0)", tag, grid_x, grid_y); end
        drive_pixels(0, 64, st);
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL %s_stalls got %0d exp 0", tag, st); end
        n_checks++; if (reg_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_early got %b exp 0", tag, reg_valid); end
        @(negedge clk);
        pix_valid = 1'b0;
        n_checks++; if (reg_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid_latency got %b exp 1", tag, reg_valid); end
        n_checks++; if (area_err !== 16'd384) begin n_fail++; $display("FAIL %s_area got %0d exp 384", tag, area_err); end
        n_checks++; if (paint !== 1'b0) begin n_fail++; $display("FAIL %s_paint got %b exp 0", tag, paint); end
        n_checks++; if (region !== exp_vec) begin n_fail++; $display("FAIL %s_region mismatch at elem %0d got %0d exp 6", tag, first_diff(region, exp_vec), region[first_diff(region, exp_vec)*DW +: DW]); end
    endtask

    task automatic test_hold_stall();
        pix_valid = 1'b1; ref_rgb = 24'hFFFFFF; cvs_rgb = 24'h000000; reg_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++; if (pix_ready !== 1'b0 || reg_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hs cyc %0d got ready=%b valid=%b exp 0 1", c, pix_ready, reg_valid); end
            n_checks++; if (area_err !== 16'd384 || region !== exp_vec) begin n_fail++; $display("FAIL stall_stable cyc %0d got area %0d exp 384", c, area_err); end
        end
        reg_ready = 1'b1; ref_rgb = 24'h123456; cvs_rgb = 24'h123456;
        @(negedge clk);
        reg_ready = 1'b0;
        n_checks++; if (reg_valid !== 1'b0 || pix_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got valid=%b ready=%b exp 0 1", reg_valid, pix_ready); end
        n_checks++; if (grid_x !== 1'b1 || grid_y !== 1'b0) begin n_fail++; $display("FAIL stall_next_grid got (%0d,%0d) exp (1,0)", grid_x, grid_y); end
        n_checks++; if (area_err !== 16'd0) begin n_fail++; $display("FAIL stall_acc_clear got %0d exp 0", area_err); end
    endtask

    // Pixel 0 of this cell was already presented by test_hold_stall.
    task automatic test_single_pixel();
        int st;
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = 24'h123456; cvs_a[i] = 24'h123456;
            exp_vec[i*DW +: DW] = '0;
        end
        ref_a[27] = 24'hFFFFFF; cvs_a[27] = 24'h000000;
        exp_vec[27*DW +: DW] = DW'(765);
        drive_pixels(1, 63, st);
        n_checks++; if (reg_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got %b exp 0", reg_valid); end
        @(negedge clk);
        pix_valid = 1'b0;
        n_checks++; if (reg_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", reg_valid); end
        n_checks++; if (area_err !== 16'd765 || paint !== 1'b0) begin n_fail++; $display("FAIL single_area got %0d/%b exp 765/0", area_err, paint); end
        n_checks++; if (grid_x !== 1'b1 || grid_y !== 1'b0) begin n_fail++; $display("FAIL single_grid got (%0d,%0d) exp (1,0)", grid_x, grid_y); end
        n_checks++; if (region !== exp_vec) begin n_fail++; $display("FAIL single_region first bad elem %0d", first_diff(region, exp_vec)); end
        accept_region();
        n_checks++; if (grid_x !== 1'b0 || grid_y !== 1'b1 || frame_done !== 1'b0) begin n_fail++; $display("FAIL single_wrap got (%0d,%0d) done=%b exp (0,1) 0", grid_x, grid_y, frame_done); end
    endtask

    task automatic test_max();
        int st;
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = 24'hFFFFFF; cvs_a[i] = 24'h000000;
        end
        drive_pixels(0, 64, st);
        @(negedge clk);
        pix_valid = 1'b0;
        n_checks++; if (reg_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid got %b exp 1", reg_valid); end
        n_checks++; if (area_err !== 16'd48960) begin n_fail++; $display("FAIL max_area got %0d exp 48960", area_err); end
        n_checks++; if (paint !== 1'b1) begin n_fail++; $display("FAIL max_paint got %b exp 1", paint); end
        n_checks++; if (region[63*DW +: DW] !== DW'(765)) begin n_fail++; $display("FAIL max_elem63 got %0d exp 765", region[63*DW +: DW]); end
        accept_region();
    endtask

    task automatic load_thresh(input bit plus_one);
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = 24'h000000; cvs_a[i] = 24'h000000;
            exp_vec[i*DW +: DW] = '0;
        end
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) begin ref_a[i] = 24'h000040; cvs_a[i] = 24'h000000; end
            else begin ref_a[i] = 24'h000000; cvs_a[i] = 24'h400000; end
            exp_vec[i*DW +: DW] = DW'(64);
        end
        if (plus_one) begin
            ref_a[63] = 24'h0A0000; cvs_a[63] = 24'h090000;
            exp_vec[63*DW +: DW] = DW'(1);
        end
    endtask

    task automatic test_threshold_last();
        int st;
        int pulses = 0;
        load_thresh(1'b0);
        drive_pixels(0, 64, st);
        @(negedge clk);
        pix_valid = 1'b0;
        n_checks++; if (area_err !== 16'd3200 || paint !== 1'b0) begin n_fail++; $display("FAIL thresh_eq got %0d/%b exp 3200/0", area_err, paint); end
        n_checks++; if (grid_x !== 1'b1 || grid_y !== 1'b1) begin n_fail++; $display("FAIL thresh_grid got (%0d,%0d) exp (1,1)", grid_x, grid_y); end
        n_checks++; if (region !== exp_vec) begin n_fail++; $display("FAIL thresh_region first bad elem %0d", first_diff(region, exp_vec)); end
        reg_ready = 1'b1;
        @(negedge clk);
        reg_ready = 1'b0;
        pix_valid = 1'b1;
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL done_timing got %b exp 1", frame_done); end
        for (int c = 0; c < 6; c++) begin
            if (frame_done === 1'b1) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL done_pulses got %0d exp 1", pulses); end
        n_checks++; if (pix_ready !== 1'b0 || reg_valid !== 1'b0) begin n_fail++; $display("FAIL back_idle got ready=%b valid=%b exp 0 0", pix_ready, reg_valid); end
        pix_valid = 1'b0;
    endtask

    task automatic test_restart();
        int st;
        load_thresh(1'b1);
        start_frame();
        n_checks++; if (grid_x !== 1'b0 || grid_y !== 1'b0 || pix_ready !== 1'b1) begin n_fail++; $display("FAIL restart got (%0d,%0d) ready=%b exp (0,0) 1", grid_x, grid_y, pix_ready); end
        drive_pixels(0, 64, st);
        @(negedge clk);
        pix_valid = 1'b0;
        n_checks++; if (area_err !== 16'd3201 || paint !== 1'b1) begin n_fail++; $display("FAIL thresh_plus1 got %0d/%b exp 3201/1", area_err, paint); end
        n_checks++; if (region !== exp_vec) begin n_fail++; $display("FAIL restart_region first bad elem %0d", first_diff(region, exp_vec)); end
        accept_region();
    endtask

    task automatic test_reset_midfill();
        int st;
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = 24'hFFFFFF; cvs_a[i] = 24'h000000;
        end
        drive_pixels(0, 30, st);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pix_ready !== 1'b0 || reg_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got ready=%b valid=%b done=%b exp 0 0 0", pix_ready, reg_valid, frame_done); end
        n_checks++; if (area_err !== 16'd0 || paint !== 1'b0) begin n_fail++; $display("FAIL midrst_area got %0d/%b exp 0/0", area_err, paint); end
        n_checks++; if (grid_x !== 1'b0 || grid_y !== 1'b0) begin n_fail++; $display("FAIL midrst_grid got (%0d,%0d) exp (0,0)", grid_x, grid_y); end
        n_checks++; if (region !== '0) begin n_fail++; $display("FAIL midrst_region elem %0d nonzero exp 0", first_diff(region, '0)); end
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b exp 0", pix_ready); end
    endtask

    initial begin
        test_reset();
        test_uniform("uniform");
        test_hold_stall();
        test_single_pixel();
        test_max();
        test_threshold_last();
        test_restart();
        test_reset_midfill();
        test_uniform("recover");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/grid_diff_loader.md
Name: grid_diff_loader

Overview:
- Upstream feeder of the stroke-placement stage in the painterly renderer.
- Accepts a raster stream of (reference, canvas) RGB pixel pairs, one 8x8 grid cell at a time.
- Per pixel, computes the colour difference |dR|+|dG|+|dB|, buffers the 64 differences as an 8x8 region, and accumulates the cell's area error.
- Presents the full region, area error, paint decision and grid coordinates downstream over a valid/ready handshake. The downstream stage finds the max-difference location.

Parameters:
- DIFF_W, 24: width of each region element; the 10-bit difference is zero-extended to this width.
- GRIDS_X, 40: grid cells per image row.
- GRIDS_Y, 30: grid cells per image column.
- AREA_THRESH, 16'd3200: area-error threshold; paint when the error is strictly greater.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  start a frame; honoured only in IDLE.
- i_pix_valid  in  1  pixel pair valid.
- o_pix_ready  out  1  block accepts a pixel pair.
- i_ref_rgb  in  24  reference (blurred) pixel: [23:16] R, [15:8] G, [7:0] B.
- i_cvs_rgb  in  24  canvas pixel, same packing.
- o_region  out  64*DIFF_W  flattened region; element (row r, col c) is at index r*8+c, LSB-first.
- o_area_err  out  16  sum of the 64 differences.
- o_paint  out  1  o_area_err > AREA_THRESH.
- o_grid_x  out  $clog2(GRIDS_X)  grid column of the presented region.
- o_grid_y  out  $clog2(GRIDS_Y)  grid row of the presented region.
- o_reg_valid  out  1  region valid.
- i_reg_ready  in  1  downstream accepts the region.
- o_frame_done  out  1  one-cycle pulse after the last region of a frame is accepted.

Behaviour:
- States:
  - IDLE: o_pix_ready=0. i_start -> FILL; grid counters cleared to (0,0).
  - FILL: o_pix_ready=1. Each accepted pair (i_pix_valid & o_pix_ready) writes its difference to region[cnt[5:3]][cnt[2:0]], adds it to the accumulator and increments the 6-bit cnt. Accepting with cnt==63 -> HOLD; cnt wraps to 0.
  - HOLD: o_pix_ready=0, o_reg_valid=1. Outputs stay stable until i_reg_ready. On the handshake:
    - If grid_x==GRIDS_X-1 and grid_y==GRIDS_Y-1: pulse o_frame_done, -> IDLE.
    - Otherwise advance grid_x (wrap to 0 and increment grid_y at GRIDS_X-1), clear the accumulator, -> FILL.
- Difference arithmetic: each channel's absolute difference is computed in 8 bits, the three are summed into 10 bits (max 765), then zero-extended to DIFF_W. The 16-bit accumulator cannot overflow (max 48960).
- Latency:
  - Difference is registered in the same cycle as the accept.
  - o_reg_valid rises the cycle after the 64th accept.
  - o_area_err and o_paint are valid whenever o_reg_valid=1.
  - After the handshake, the next pixel can be accepted in the following cycle. Minimum region period is 65 cycles.
- Rules:
  - o_pix_ready does not depend combinationally on i_pix_valid.
  - o_reg_valid, once asserted, holds until accepted.
  - i_start outside IDLE is ignored.
  - i_reg_ready outside HOLD is ignored.
- Reset values: state=IDLE, all region entries 0, o_area_err=0, o_paint=0, grid counters 0, cnt=0, o_pix_ready=0, o_reg_valid=0, o_frame_done=0.
- Reset mid-fill or mid-hold discards the partial region immediately, and no handshake completes in that cycle.

Decomposition:
- Package paint_pkg holds:
  - rgb_t: 24-bit packed R/G/B.
  - diff_t: 10-bit difference.
  - GRID_SZ = 8 and GRID_PIX = 64.
  - The state enum {IDLE, FILL, HOLD}.
- One natural sub-module, color_abs_diff: combinational, two rgb_t in, diff_t out. Instantiated once.

Test Plan:
- Reset then i_start with 64 pairs of ref=24'h000000, cvs=24'h010203 -> every region element is 6, o_area_err=384, o_paint=0, grid (0,0), o_reg_valid one cycle after the 64th accept.
- Pixel 27 uses ref=24'hFFFFFF, cvs=24'h000000; all others are equal -> element index 27 (row 3, col 3) = 765, o_area_err=765, o_paint=0.
- All 64 pairs at maximum difference (FFFFFF vs 000000) -> o_area_err=48960, o_paint=1.
- Hold i_reg_ready=0 for 20 cycles in HOLD while i_pix_valid=1 -> o_pix_ready=0, outputs stable, no pixel consumed. Assert ready -> next cell grid (1,0), and its first pixel is accepted the next cycle.
- GRIDS_X=2, GRIDS_Y=2: stream 4 cells -> coordinates (0,0),(1,0),(0,1),(1,1), o_frame_done pulses once, return to IDLE. A following i_start restarts at (0,0).
- Assert i_rst_n low after 30 pixels -> all outputs return to reset values. After a new i_start, a full 64-pixel cell produces the correct sum with no residue from the aborted cell.
